viterbi_decoder_param: RTL and testbench

VITERBI_DECODER_PARAM -- requirements
Module: viterbi_decoder_param

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/viterbi_acs.sv | 41 ++++
 rtl/viterbi_decoder_param.sv | 116 +++++++++++
 tb/tb_viterbi_decoder_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the parameterised hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int MAX_K = 7;

    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    // Encoder output {c0,c1} for input bit b leaving state; b sits at tap position k-1.
    function automatic logic [1:0] expected_symbol(input int g0, input int g1, input int k,
                                                   input logic b, input int state);
        logic [MAX_K-1:0] taps;
        taps = MAX_K'(state) | (MAX_K'(b) << (k - 1));
        return {^(taps & MAX_K'(g0)), ^(taps & MAX_K'(g1))};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state; predecessor order and branch symbols fixed at elaboration.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int K     = 3,
    parameter int G0    = 7,
    parameter int G1    = 5,
    parameter int TB    = 15,
    parameter int PMW   = 6,
    parameter int STATE = 0
) (
    input  logic [1:0]     symbol,
    input  logic [PMW-1:0] pm0,
    input  logic [PMW-1:0] pm1,
    input  logic [TB-2:0]  surv0,
    input  logic [TB-2:0]  surv1,
    output logic [PMW-1:0] pm_sum,
    output logic [TB-1:0]  surv_new
);

    localparam int         NS   = num_states(K);
    localparam int         P0   = (2 * STATE) % NS;
    localparam int         P1   = P0 + 1;
    localparam logic       B    = 1'((STATE >> (K - 2)) & 1);
    localparam logic [1:0] EXP0 = expected_symbol(G0, G1, K, B, P0);
    localparam logic [1:0] EXP1 = expected_symbol(G0, G1, K, B, P1);

    logic [PMW-1:0] sum0;
    logic [PMW-1:0] sum1;
    logic           take1;

    // NOTE: combinational logic uses blocking assignments and assigns every output on every pass.
    always_comb begin
        sum0     = pm0 + PMW'(hamming(symbol, EXP0));
        sum1     = pm1 + PMW'(hamming(symbol, EXP1));
        take1    = sum1 < sum0;   // strict compare: ties keep the predecessor ending in 0
        pm_sum   = take1 ? sum1 : sum0;
        surv_new = {take1 ? surv1 : surv0, B};
    end

endmodule

// File: rtl/viterbi_decoder_param.sv
// Register-exchange hard-decision Viterbi decoder, rate 1/2, constraint length K.
module viterbi_decoder_param
    import viterbi_pkg::*;
#(
    parameter int K   = 3,
    parameter int G0  = 7,
    parameter int G1  = 5,
    parameter int TB  = 15,
    parameter int PMW = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       in_valid,
    input  logic [1:0] encoded_signal,
    output logic       out_valid,
    output logic       decoded_signal
);

    localparam int             NS        = num_states(K);
    localparam int             SW        = K - 1;
    localparam int             CW        = $clog2(TB);
    localparam logic [PMW-1:0] PM_INIT   = PMW'(2 * K);
    localparam logic [CW-1:0]  COUNT_MAX = CW'(TB - 1);

    if (K < 3 || K > MAX_K) begin : g_bad_k
        $error("viterbi_decoder_param: K must be 3..7");
    end
    if (TB < 4 || TB > 64) begin : g_bad_tb
        $error("viterbi_decoder_param: TB must be 4..64");
    end
    if ((1 << (PMW - 1)) <= 4 * K) begin : g_bad_pmw
        $error("viterbi_decoder_param: PMW too narrow for K");
    end

    // Stored survivors keep TB-1 bits; the oldest bit is taken straight from the new survivor.
    logic [PMW-1:0] pm_q     [NS];
    logic [PMW-1:0] pm_cur   [NS];
    logic [PMW-1:0] pm_sum   [NS];
    logic [PMW-1:0] pm_next  [NS];
    logic [TB-2:0]  surv_q   [NS];
    logic [TB-2:0]  surv_cur [NS];
    logic [TB-1:0]  surv_new [NS];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_cur;
    logic [SW-1:0]  best;
    logic           all_msb;

    // A restart alongside in_valid feeds the ACS array from the initial trellis.
    always_comb begin
        count_cur = restart ? '0 : count_q;
        for (int s = 0; s < NS; s++) begin
            pm_cur[s]   = restart ? ((s == 0) ? '0 : PM_INIT) : pm_q[s];
            surv_cur[s] = restart ? '0 : surv_q[s];
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_acs
        localparam int P0 = (2 * g) % NS;
        viterbi_acs #(
            .K(K), .G0(G0), .G1(G1), .TB(TB), .PMW(PMW), .STATE(g)
        ) u_acs (
            .symbol  (encoded_signal),
            .pm0     (pm_cur[P0]),
            .pm1     (pm_cur[P0 + 1]),
            .surv0   (surv_cur[P0]),
            .surv1   (surv_cur[P0 + 1]),
            .pm_sum  (pm_sum[g]),
            .surv_new(surv_new[g])
        );
    end

    always_comb begin
        all_msb = 1'b1;
        for (int s = 0; s < NS; s++) all_msb = all_msb & pm_sum[s][PMW-1];
        for (int s = 0; s < NS; s++) begin
            pm_next[s]        = pm_sum[s];
            pm_next[s][PMW-1] = pm_sum[s][PMW-1] & ~all_msb;
        end
        best = '0;
        for (int s = 1; s < NS; s++) begin
            if (pm_next[s] < pm_next[best]) best = SW'(s);
        end
    end

    // NOTE: metric and survivor arrays are reset so decoding always starts from the all-zero state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            decoded_signal <= 1'b0;
            count_q        <= '0;
            for (int s = 0; s < NS; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
                surv_q[s] <= '0;
            end
        end else if (in_valid) begin
            out_valid      <= (count_cur == COUNT_MAX);
            decoded_signal <= surv_new[best][TB-1];
            count_q        <= (count_cur == COUNT_MAX) ? count_cur : count_cur + 1'b1;
            for (int s = 0; s < NS; s++) begin
                pm_q[s]   <= pm_next[s];
                surv_q[s] <= surv_new[s][TB-2:0];
            end
        end else if (restart) begin
            out_valid <= 1'b0;
            count_q   <= '0;
            for (int s = 0; s < NS; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
                surv_q[s] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed bench for viterbi_decoder_param at K=3, G=(7,5), TB=15, PMW=6.
module tb_viterbi_decoder_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] encoded_signal = 2'd0;
    logic       out_valid;
    logic       decoded_signal;

    int   checks = 0;
    int   errors = 0;
    logic got_q[$];
    int   sym_count;
    int   first_valid;
    bit   gap_hi;
    logic [1:0] enc_state;

    // Bits 1,0,1,1,0,0 encode to 3,2,0,1,1,3; ref_bits[i] is bit i.
    int         vec_a [6] = '{3, 2, 0, 1, 1, 3};
    logic [5:0] ref_bits = 6'b001101;

    viterbi_decoder_param #(
        .K(3), .G0(7), .G1(5), .TB(15), .PMW(6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart),
        .in_valid      (in_valid),
        .encoded_signal(encoded_signal),
        .out_valid     (out_valid),
        .decoded_signal(decoded_signal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic start_run();
        got_q.delete();
        sym_count   = 0;
        first_valid = -1;
        gap_hi      = 1'b0;
    endtask

    // One clock: drive inputs, let the edge pass, then sample outputs 1 ns later.
    task automatic step(input bit v, input logic [1:0] sym, input bit rs);
        in_valid       = v;
        encoded_signal = sym;
        restart        = rs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        restart  = 1'b0;
        if (v) sym_count++;
        if (out_valid === 1'b1) begin
            got_q.push_back(decoded_signal);
            if (first_valid < 0) first_valid = sym_count;
            if (!v) gap_hi = 1'b1;
        end
    endtask

    task automatic encode(input logic b, output logic [1:0] sym);
        sym       = {^({b, enc_state} & 3'b111), ^({b, enc_state} & 3'b101)};
        enc_state = {b, enc_state[1]};
    endtask

    task automatic run_vector(input bit flip, input int gap, input bit rs_first);
        logic [1:0] sym;
        for (int i = 0; i < 20; i++) begin
            sym = (i < 6) ? 2'(vec_a[i]) : 2'd0;
            if (flip && i == 2) sym = 2'd2;
            step(1'b1, sym, rs_first && (i == 0));
            repeat (gap) step(1'b0, 2'd0, 1'b0);
        end
    endtask

    task automatic check_vector(input string tag);
        check({tag, "_first_valid"}, first_valid, 15);
        check({tag, "_n_out"}, got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_bit%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(ref_bits[i]));
        end
    endtask

    initial begin
        logic [1:0] sym;
        logic       rnd_bits [200];
        int         mism;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_decoded", decoded_signal, 0);
        reset = 1'b1;

        // Error-free directed stream.
        start_run();
        run_vector(1'b0, 0, 1'b0);
        check_vector("clean");

        // Single channel error on symbol 2.
        step(1'b0, 2'd0, 1'b1);
        start_run();
        run_vector(1'b1, 0, 1'b0);
        check_vector("flip");

        // Three idle cycles after every symbol.
        step(1'b0, 2'd0, 1'b1);
        start_run();
        run_vector(1'b0, 3, 1'b0);
        check_vector("gaps");
        check("gaps_quiet", gap_hi, 0);

        // 200 random bits through the reference encoder.
        step(1'b0, 2'd0, 1'b1);
        start_run();
        enc_state = 2'b00;
        for (int i = 0; i < 200; i++) begin
            rnd_bits[i] = 1'($urandom_range(0, 1));
            encode(rnd_bits[i], sym);
            step(1'b1, sym, 1'b0);
        end
        check("rnd_first_valid", first_valid, 15);
        check("rnd_n_out", got_q.size(), 186);
        mism = 0;
        for (int n = 0; n < got_q.size() && n < 200; n++) begin
            if (got_q[n] !== rnd_bits[n]) mism++;
        end
        check("rnd_mismatches", mism, 0);

        // Asynchronous reset after 8 symbols, then resume without restart.
        step(1'b0, 2'd0, 1'b1);
        enc_state = 2'b00;
        for (int i = 0; i < 8; i++) begin
            encode(1'($urandom_range(0, 1)), sym);
            step(1'b1, sym, 1'b0);
        end
        #3;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_decoded", decoded_signal, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        start_run();
        run_vector(1'b0, 0, 1'b0);
        check_vector("midrst");

        // Restart together with the first symbol of a new stream mid-flight.
        enc_state = 2'b00;
        for (int i = 0; i < 10; i++) begin
            encode(1'($urandom_range(0, 1)), sym);
            step(1'b1, sym, 1'b0);
        end
        start_run();
        run_vector(1'b0, 0, 1'b1);
        check_vector("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
